// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// WIDTH steps per product, with a one-cycle done pulse and a registered result.
module booth_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic                        busy,
  output logic                        done,
  output logic signed [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       acc_sh;
  logic [WIDTH-1:0]     mq_sh;

  // The accumulator is one bit wider than the operands so that subtracting
  // the most negative multiplicand cannot overflow.
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({mq_q[0], q1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    mq_sh  = {sum[0], mq_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          acc_d   = '0;
          mq_d    = b;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        mq_d  = mq_sh;
        q1_d  = mq_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = {acc_sh[WIDTH-1:0], mq_sh};
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl at WIDTH=4: expected products are queued when a
// multiply is launched and popped when the done pulse arrives.
module tb_booth_seq_ctrl;

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [3:0] a;
  logic signed [3:0] b;
  logic              busy;
  logic              done;
  logic signed [7:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  booth_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply from IDLE (caller sits at a negedge) and wait for done.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                       output logic [7:0] res, output int bcyc,
                       output logic got, output logic overlap,
                       output logic done_after);
    int p;
    p = $signed(av) * $signed(bv);
    sb.push_back(p[7:0]);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0; got = 1'b0; overlap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcyc++;
      @(negedge clk);
    end
    res = result;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 4'sd3; b = 4'sd3;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++;
    if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", result); end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] res, exp;
    int bc; logic got, ov, da;
    do_op(4'sd3, 4'sd7, res, bc, got, ov, da);
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done_seen got=%b exp=1", got); end
    n_checks++;
    if (bc != 4) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    n_checks++;
    if (res !== exp || exp !== 8'h15) begin n_fail++; $display("FAIL basic_result got=%h exp=15", res); end
    n_checks++;
    if (ov !== 1'b0 || da !== 1'b0) begin n_fail++; $display("FAIL basic_done_shape overlap=%b done_after=%b exp=0,0", ov, da); end
  endtask

  task automatic test_vectors();
    logic [3:0] va[5] = '{4'hD, 4'h3, 4'h5, 4'h8, 4'h8};
    logic [3:0] vb[5] = '{4'h4, 4'h9, 4'h6, 4'h8, 4'h7};
    logic [7:0] vexp[5] = '{8'hF4, 8'hEB, 8'h1E, 8'h40, 8'hC8};
    logic [7:0] res, exp;
    int bc; logic got, ov, da;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], res, bc, got, ov, da);
      exp = sb.pop_front();
      n_checks++;
      if (res !== exp || res !== vexp[i] || got !== 1'b1 || bc != 4)
        begin n_fail++; $display("FAIL vector_%0d got=%h exp=%h done=%b busy_cycles=%0d", i, res, vexp[i], got, bc); end
    end
  endtask

  task automatic test_start_held();
    logic [7:0] exp;
    logic got;
    int p;
    p = 2 * 3;
    sb.push_back(p[7:0]);
    start = 1'b1; a = 4'sd2; b = 4'sd3;
    @(negedge clk);
    a = 4'sd7; b = 4'sd7;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || result !== exp) begin n_fail++; $display("FAIL held_first got=%h exp=%h done=%b", result, exp, got); end
    p = 7 * 7;
    sb.push_back(p[7:0]);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL held_idle_after_done busy=%b done=%b exp=0,0", busy, done); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart busy=%b exp=1", busy); end
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || result !== exp || exp !== 8'd49) begin n_fail++; $display("FAIL held_second got=%h exp=31 done=%b", result, got); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] res, exp;
    int bc; logic got, ov, da, seen_done;
    start = 1'b1; a = 4'sd5; b = 4'sd3;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0;
    repeat (2) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) seen_done = 1'b1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_checks++;
    if (result !== 8'h00) begin n_fail++; $display("FAIL abort_result got=%h exp=00", result); end
    rst = 1'b0;
    repeat (6) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(4'sd1, 4'hF, res, bc, got, ov, da);
    exp = sb.pop_front();
    n_checks++;
    if (res !== exp || exp !== 8'hFF || got !== 1'b1 || bc != 4)
      begin n_fail++; $display("FAIL abort_restart got=%h exp=ff done=%b busy_cycles=%0d", res, got, bc); end
  endtask

  task automatic test_sweep();
    logic [7:0] res, exp;
    int bc; logic got, ov, da;
    logic [3:0] av, bv;
    int errs;
    errs = 0;
    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        av = ai[3:0]; bv = bi[3:0];
        do_op(av, bv, res, bc, got, ov, da);
        exp = sb.pop_front();
        n_checks++;
        if (res !== exp) begin n_fail++; errs++;
          if (errs < 10) $display("FAIL sweep_result a=%0d b=%0d got=%h exp=%h", ai, bi, res, exp); end
        n_checks++;
        if (got !== 1'b1 || da !== 1'b0 || ov !== 1'b0 || bc != 4) begin n_fail++; errs++;
          if (errs < 10) $display("FAIL sweep_handshake a=%0d b=%0d done=%b done_after=%b overlap=%b busy_cycles=%0d exp=1,0,0,4", ai, bi, got, da, ov, bc); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_start_held();
    test_abort();
    test_sweep();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
